// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity tracker.
package serial_parity_pkg;

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } state_e;

  // Saturation value of an unsigned counter that is w bits wide.
  function automatic logic [31:0] cnt_sat(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/serial_parity_fsm.sv
// Two-state parity FSM with a registered, polarity-selectable parity output.
//  state  | meaning
//  S_EVEN | even number of ones accepted since the last restart
//  S_ODD  | odd number of ones accepted since the last restart
module serial_parity_fsm
  import serial_parity_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic load_i,
  input  logic toggle_i,
  input  logic x_i,
  output logic p_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_EVEN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i)       state_d = S_EVEN;
    else if (load_i)   state_d = x_i ? S_ODD : S_EVEN;
    else if (toggle_i) state_d = (state_q == S_ODD) ? S_EVEN : S_ODD;
  end

  assign p_o = (state_q == S_ODD) ^ ODD_PARITY;

endmodule

// File: rtl/serial_parity.sv
// Serial parity tracker: bit counter, optional fixed-length framing, clear.
module serial_parity
  import serial_parity_pkg::*;
#(
  parameter bit          ODD_PARITY = 1'b0,
  parameter int unsigned FRAME_LEN  = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             en,
  input  logic             clr,
  output logic             p,
  output logic             frame_done,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_sat(CNT_W));
  localparam logic [CNT_W-1:0] FRAME_N = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               FRAMED  = (FRAME_LEN != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fd_q, fd_d;
  logic             frame_full, fsm_clear, fsm_load, fsm_toggle;

  // A completed frame stays "full" through idle cycles until the next accepted bit.
  assign frame_full = FRAMED && (cnt_q == FRAME_N);
  assign fsm_clear  = clr & ~en;
  assign fsm_load   = en & (clr | frame_full);
  assign fsm_toggle = en & ~fsm_load & x;

  always_comb begin
    cnt_d = cnt_q;
    if (fsm_clear)                     cnt_d = '0;
    else if (fsm_load)                 cnt_d = CNT_ONE;
    else if (en && (cnt_q != CNT_SAT)) cnt_d = cnt_q + CNT_ONE;
    fd_d = FRAMED && en && (cnt_d == FRAME_N);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fd_q  <= fd_d;
    end
  end

  serial_parity_fsm #(
    .ODD_PARITY(ODD_PARITY)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (fsm_clear),
    .load_i  (fsm_load),
    .toggle_i(fsm_toggle),
    .x_i     (x),
    .p_o     (p)
  );

  assign bit_cnt    = cnt_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_serial_parity.sv
// Directed-vector bench for serial_parity across four parameter sets.
module tb_serial_parity;

  logic clk = 1'b0;
  logic rst_n, x, en, clr;

  logic       p_e, fd_e;
  logic [7:0] cnt_e;
  logic       p_o, fd_o;
  logic [7:0] cnt_o;
  logic       p_f, fd_f;
  logic [7:0] cnt_f;
  logic       p_s, fd_s;
  logic [2:0] cnt_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_parity u_even (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .clr(clr),
    .p(p_e), .frame_done(fd_e), .bit_cnt(cnt_e)
  );

  serial_parity #(.ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .clr(clr),
    .p(p_o), .frame_done(fd_o), .bit_cnt(cnt_o)
  );

  serial_parity #(.FRAME_LEN(4)) u_frm (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .clr(clr),
    .p(p_f), .frame_done(fd_f), .bit_cnt(cnt_f)
  );

  serial_parity #(.CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .clr(clr),
    .p(p_s), .frame_done(fd_s), .bit_cnt(cnt_s)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic xv, input logic ev, input logic cv);
    x = xv; en = ev; clr = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] s_x, s_pe, s_po;
    logic [7:0] f_x, f_p, f_fd;
    logic [7:0] f_cnt [8];
    rst_n = 1'b0; x = 1'b0; en = 1'b0; clr = 1'b0;

    // Reset state and basic streaming
    do_reset();
    chk("rst_p_even", {7'd0, p_e}, 8'd0);
    chk("rst_cnt_even", cnt_e, 8'd0);
    chk("rst_p_odd", {7'd0, p_o}, 8'd1);
    chk("rst_fd_frm", {7'd0, fd_f}, 8'd0);
    s_x  = 6'b101101;  // bit 0 first: 1,0,1,1,0,1
    s_pe = 6'b011011;  // 1,1,0,1,1,0
    s_po = 6'b100100;  // 0,0,1,0,0,1
    for (int i = 0; i < 6; i++) begin
      step(s_x[i], 1'b1, 1'b0);
      chk("stream_p_even", {7'd0, p_e}, {7'd0, s_pe[i]});
      chk("stream_p_odd", {7'd0, p_o}, {7'd0, s_po[i]});
      chk("stream_cnt", cnt_e, 8'(i + 1));
      chk("stream_fd_cont", {7'd0, fd_e}, 8'd0);
    end

    // en gating
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("en_p0", {7'd0, p_e}, 8'd1);  chk("en_cnt0", cnt_e, 8'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("en_p1", {7'd0, p_e}, 8'd1);  chk("en_cnt1", cnt_e, 8'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("en_p2", {7'd0, p_e}, 8'd1);  chk("en_cnt2", cnt_e, 8'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("en_p3", {7'd0, p_e}, 8'd1);  chk("en_cnt3", cnt_e, 8'd2);

    // clr with and without en
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("clr_pre_p", {7'd0, p_e}, 8'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("clr_noen_p", {7'd0, p_e}, 8'd0);
    chk("clr_noen_cnt", cnt_e, 8'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_en_p", {7'd0, p_e}, 8'd1);
    chk("clr_en_cnt", cnt_e, 8'd1);

    // Framed mode, FRAME_LEN=4
    do_reset();
    f_x  = 8'b00010111;  // 1,1,1,0,1,0,0,0
    f_p  = 8'b11111101;  // 1,0,1,1,1,1,1,1
    f_fd = 8'b10001000;  // pulse after 4th and 8th bits
    f_cnt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4};
    for (int i = 0; i < 8; i++) begin
      step(f_x[i], 1'b1, 1'b0);
      chk("frm_p", {7'd0, p_f}, {7'd0, f_p[i]});
      chk("frm_fd", {7'd0, fd_f}, {7'd0, f_fd[i]});
      chk("frm_cnt", cnt_f, f_cnt[i]);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("frm_idle_fd", {7'd0, fd_f}, 8'd0);
    chk("frm_idle_p", {7'd0, p_f}, 8'd1);
    chk("frm_idle_cnt", cnt_f, 8'd4);
    step(1'b0, 1'b1, 1'b0);
    chk("frm_after_idle_p", {7'd0, p_f}, 8'd0);
    chk("frm_after_idle_cnt", cnt_f, 8'd1);

    // Reset mid-frame discards partial frame
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_pre_cnt", cnt_f, 8'd2);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("mid_rst_p", {7'd0, p_f}, 8'd0);
    chk("mid_rst_cnt", cnt_f, 8'd0);
    chk("mid_rst_fd", {7'd0, fd_f}, 8'd0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("mid_post_cnt", cnt_f, 8'd2);
    chk("mid_post_fd", {7'd0, fd_f}, 8'd0);
    chk("mid_post_p", {7'd0, p_f}, 8'd1);

    // Saturation with CNT_W=3
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("sat_cnt", {5'd0, cnt_s}, (i > 7) ? 8'd7 : 8'(i));
      chk("sat_p", {7'd0, p_s}, 8'(i % 2));
      chk("sat_fd", {7'd0, fd_s}, 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
